pll_phase_ctrl: RTL



---
 rtl/pll_phase_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL supervisor and dynamic-phase sequencer.
// Pulses the PLL reset, qualifies LOCK with a timeout/retry loop, produces a
// clean fabric reset, and turns phase-step requests into PHASESEL/PHASEDIR/
// PHASESTEP/PHASELOADREG sequences one request at a time.
module pll_phase_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 250000,
  parameter int STABLE_CYCLES = 1024,
  parameter int PULSE_CYCLES  = 4,
  parameter int GAP_CYCLES    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep,
  output logic       pll_phaseloadreg,
  input  logic       step_valid,
  output logic       step_ready,
  input  logic [1:0] step_sel,
  input  logic       step_dir,
  input  logic [3:0] step_count,
  output logic       rst_out,
  output logic [7:0] retries
);

  localparam int MAX_LS = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int MAX_RP = (RST_CYCLES > PULSE_CYCLES + GAP_CYCLES) ?
                          RST_CYCLES : PULSE_CYCLES + GAP_CYCLES;
  localparam int MAX_C  = (MAX_LS > MAX_RP) ? MAX_LS : MAX_RP;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PULSE_CYCLES + GAP_CYCLES - 1);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_IDLE      = 3'd3;
  localparam logic [2:0] S_SETUP     = 3'd4;
  localparam logic [2:0] S_STEP      = 3'd5;
  localparam logic [2:0] S_LOAD      = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    steps_left;
  logic          abort;
  logic          lk_meta;
  logic          lk;
  logic          abort_now;

  // A lock drop seen during a pulse is remembered so the pulse can finish first.
  assign abort_now = abort | ~lk;

  // Two-flop synchronizer bringing the asynchronous PLL LOCK into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  // Supervisor / phase-sequencer state machine with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_PLL_RST;
      cnt              <= '0;
      steps_left       <= '0;
      abort            <= 1'b0;
      pll_rst          <= 1'b1;
      rst_out          <= 1'b1;
      step_ready       <= 1'b0;
      retries          <= '0;
      pll_phasesel     <= '0;
      pll_phasedir     <= 1'b1;
      pll_phasestep    <= 1'b1;
      pll_phaseloadreg <= 1'b1;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == RST_LAST) begin
            pll_rst <= 1'b0;
            cnt     <= '0;
            state   <= S_WAIT_LOCK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            cnt   <= '0;
            state <= S_STABLE;
          end else if (cnt == LOCK_LAST) begin
            if (retries != 8'hFF) retries <= retries + 8'd1;
            pll_rst <= 1'b1;
            cnt     <= '0;
            state   <= S_PLL_RST;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STABLE: begin
          if (!lk) begin
            cnt   <= '0;
            state <= S_WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            rst_out    <= 1'b0;
            step_ready <= 1'b1;
            cnt        <= '0;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (!lk) begin
            rst_out    <= 1'b1;
            step_ready <= 1'b0;
            cnt        <= '0;
            state      <= S_WAIT_LOCK;
          end else if (step_valid) begin
            pll_phasesel <= step_sel;
            pll_phasedir <= step_dir;
            steps_left   <= step_count;
            step_ready   <= 1'b0;
            cnt          <= '0;
            state        <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!lk) begin
            rst_out <= 1'b1;
            cnt     <= '0;
            state   <= S_WAIT_LOCK;
          end else if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (steps_left == 4'd0) begin
              pll_phaseloadreg <= 1'b0;
              state            <= S_LOAD;
            end else begin
              pll_phasestep <= 1'b0;
              state         <= S_STEP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STEP: begin
          cnt <= cnt + CW'(1);
          if (cnt == PULSE_LAST) begin
            pll_phasestep <= 1'b1;
            if (abort_now) begin
              abort   <= 1'b0;
              rst_out <= 1'b1;
              cnt     <= '0;
              state   <= S_WAIT_LOCK;
            end
          end else if (cnt < PULSE_LAST) begin
            if (!lk) abort <= 1'b1;
          end else if (!lk) begin
            rst_out <= 1'b1;
            cnt     <= '0;
            state   <= S_WAIT_LOCK;
          end else if (cnt == PERIOD_LAST) begin
            cnt <= '0;
            if (steps_left == 4'd1) begin
              pll_phaseloadreg <= 1'b0;
              state            <= S_LOAD;
            end else begin
              steps_left    <= steps_left - 4'd1;
              pll_phasestep <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          cnt <= cnt + CW'(1);
          if (cnt == PULSE_LAST) begin
            pll_phaseloadreg <= 1'b1;
            if (abort_now) begin
              abort   <= 1'b0;
              rst_out <= 1'b1;
              cnt     <= '0;
              state   <= S_WAIT_LOCK;
            end
          end else if (cnt < PULSE_LAST) begin
            if (!lk) abort <= 1'b1;
          end else if (!lk) begin
            rst_out <= 1'b1;
            cnt     <= '0;
            state   <= S_WAIT_LOCK;
          end else if (cnt == PERIOD_LAST) begin
            step_ready <= 1'b1;
            cnt        <= '0;
            state      <= S_IDLE;
          end
        end
        default: begin
          pll_rst <= 1'b1;
          rst_out <= 1'b1;
          cnt     <= '0;
          state   <= S_PLL_RST;
        end
      endcase
    end
  end

endmodule
